udm_mac_acc: RTL
================

UDM_MAC_ACC -- requirements
Module: udm_mac_acc

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand width; W a power of two, W >= 2.
REQ-002 SHALL have parameter ACC_W, default 2*W+8, meaning accumulator width; ACC_W >= 2*W.
REQ-003 SHALL have parameter LEN_W, default 8, meaning width of the vector-length field.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin a new dot-product; sampled only in IDLE.
REQ-007 len  input  LEN_W  number of operand pairs; sampled with start.
REQ-008 in_valid  input  1  operand pair valid.
REQ-009 in_ready  output  1  block accepts an operand pair.
REQ-010 in1, in2  input  W each  unsigned operands.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 acc_out  output  ACC_W  accumulated sum of approximate products.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 ovf  output  1  sticky saturation flag for the current job.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE with start=1 and len!=0 SHALL go to RUN, clear the accumulator, clear ovf and load the remaining count with len.
REQ-018 IDLE with start=1 and len==0 SHALL go directly to DONE with acc_out=0 and ovf=0.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 in_ready SHALL be 1 only in RUN; a pair is accepted on an edge where in_valid && in_ready.
REQ-021 Pipeline stage A SHALL register the accepted pair at the handshake edge.
REQ-022 Stage B SHALL register the approximate product of stage A on the next edge; the product is 2*W bits and zero-extended to ACC_W.
REQ-023 Stage C SHALL add the stage-B product into the accumulator on the following edge.
REQ-024 Each stage SHALL carry a valid bit, and bubbles (in_valid=0) SHALL NOT alter the accumulator.
REQ-025 On acceptance of the last pair (count reaches 0), RUN SHALL go to DRAIN.
REQ-026 DRAIN SHALL go to DONE on the same edge that stage C absorbs the last product, so out_valid rises 2 edges after the last handshake edge.
REQ-027 Accumulation SHALL saturate at 2^ACC_W-1 and set ovf, which stays set until the next accepted start.
REQ-028 In DONE, out_valid=1 and acc_out/ovf SHALL hold stable until out_valid && out_ready; on that edge the FSM returns to IDLE.
REQ-029 acc_out SHALL be driven from the accumulator register at all times; it is meaningful only while out_valid=1.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, clear all pipeline valid bits, and set acc_out=0, ovf=0, out_valid=0, in_ready=0, busy=0.
REQ-031 Reset asserted mid-job SHALL discard the job; no partial result SHALL be emitted after reset release.
REQ-032 Datapath registers without valid bits are not required to be reset.

Structure
REQ-033 The FSM state enum and the stage-count constant (2) SHALL live in the shared package udm_pkg.
REQ-034 Stage B SHALL instantiate the library approximate multiplier UDM_nxnA with W passed through; no other sub-module is used.

Verification
REQ-035 W=4, len=1, pair (5,6) -> acc_out=30, ovf=0, out_valid 2 edges after the handshake.
REQ-036 W=4, len=1, pair (3,3) -> acc_out=7, which checks the approximate 2x2 digit result.
REQ-037 W=4, ACC_W=8, len=2, pairs (15,15),(15,15) -> each product 175; acc_out=255, ovf=1.
REQ-038 len=3 with in_valid toggling 1,0,1,0,1, then out_ready held low 4 cycles -> correct sum, out_valid and acc_out stable until out_ready, then IDLE.
REQ-039 len=0 start -> DONE next edge, acc_out=0; a start asserted during RUN is ignored.
REQ-040 rst_n pulsed low after 2 of 4 pairs -> IDLE, out_valid never asserted, and a following len=1 job (2,2) returns 4.

Source files
------------

// File: rtl/udm_pkg.sv
// rtl/udm_pkg.sv - shared FSM states and pipeline constants for the approximate MAC
package udm_pkg;

    // Job-level controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } udm_state_e;

    // Register stages between the operand handshake and the accumulator (A and B)
    localparam int unsigned UDM_STAGES = 2;

endpackage

// File: rtl/UDM_nxnA.sv
// rtl/UDM_nxnA.sv - unsigned WxW approximate multiplier built from under-designed 2x2 digits
module UDM_nxnA #(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    localparam int ND = W / 2;
    localparam int PW = 2 * W;

    // 2x2 digit product; 3x3 yields 7 so every digit product fits in 3 bits
    function automatic logic [3:0] udm2(input logic [1:0] x, input logic [1:0] y);
        if (x == 2'd3 && y == 2'd3) begin
            return 4'd7;
        end
        return {2'b00, x} * {2'b00, y};
    endfunction

    // The recursive split with exact adders flattens to a shifted sum of all digit products
    always_comb begin
        p = '0;
        for (int i = 0; i < ND; i++) begin
            for (int j = 0; j < ND; j++) begin
                p = p + (PW'(udm2(a[2*i +: 2], b[2*j +: 2])) << (2 * (i + j)));
            end
        end
    end

endmodule

// File: rtl/udm_mac_acc.sv
// rtl/udm_mac_acc.sv - saturating dot-product accumulator over an approximate multiplier
module udm_mac_acc
    import udm_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 2 * W + 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in1,
    input  logic [W-1:0]     in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             busy,
    output logic             ovf
);

    // Pipeline occupancy {B, A}: the last product is in flight to C when only B is valid
    localparam logic [UDM_STAGES-1:0] LAST_IN_C = {1'b1, {(UDM_STAGES-1){1'b0}}};

    udm_state_e       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             a_valid_q, a_valid_d;
    logic [W-1:0]     a_in1_q, a_in1_d;
    logic [W-1:0]     a_in2_q, a_in2_d;
    logic             b_valid_q, b_valid_d;
    logic [2*W-1:0]   b_prod_q, b_prod_d;

    logic [2*W-1:0]        mult_p;
    logic [ACC_W:0]        acc_sum;
    logic                  accept;
    logic [UDM_STAGES-1:0] pipe_valid;

    UDM_nxnA #(
        .W (W)
    ) u_mul (
        .a (a_in1_q),
        .b (a_in2_q),
        .p (mult_p)
    );

    assign accept     = in_valid && (state_q == ST_RUN);
    assign pipe_valid = {b_valid_q, a_valid_q};
    assign acc_sum    = {1'b0, acc_q} + {{(ACC_W + 1 - 2 * W){1'b0}}, b_prod_q};
    assign acc_out    = acc_q;
    assign ovf        = ovf_q;

    // Pipeline advance, saturating accumulate, controller next-state and status outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != ST_IDLE);

        a_valid_d = accept;
        a_in1_d   = accept ? in1 : a_in1_q;
        a_in2_d   = accept ? in2 : a_in2_q;
        b_valid_d = a_valid_q;
        b_prod_d  = a_valid_q ? mult_p : b_prod_q;

        if (b_valid_q) begin
            if (acc_sum[ACC_W]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (accept) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_valid == LAST_IN_C) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and valid bits; reset discards any job in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
        end
    end

    // Operand and product registers, qualified by the valid bits above
    always_ff @(posedge clk) begin
        a_in1_q  <= a_in1_d;
        a_in2_q  <= a_in2_d;
        b_prod_q <= b_prod_d;
    end

endmodule
